// File: rtl/digit_bbox_tracker.sv
// Tracks the bounding box of qualified horizontal black runs across a raster frame
// and reports it, registered, with a one-cycle valid pulse at end of frame.
module digit_bbox_tracker #(
    parameter int X_W     = 9,
    parameter int Y_W     = 9,
    parameter int RUN_W   = 9,
    parameter int MIN_RUN = 10
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           en,
    input  logic           frame_start,
    input  logic           frame_end,
    input  logic           line_end,
    input  logic           pix_valid,
    input  logic           pix_black,
    input  logic [X_W-1:0] hcount,
    input  logic [Y_W-1:0] vcount,
    output logic [X_W-1:0] left,
    output logic [X_W-1:0] right,
    output logic [Y_W-1:0] top,
    output logic [Y_W-1:0] bottom,
    output logic           bbox_valid,
    output logic           bbox_empty,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(MIN_RUN);

    state_t           r_state;
    state_t           w_nextState;
    logic             w_process;
    logic             w_report;
    logic             w_clear;

    logic [RUN_W-1:0] r_runCount;
    logic [X_W-1:0]   r_runStart;
    logic [X_W-1:0]   r_runLast;
    logic [X_W-1:0]   r_leftAcc;
    logic [X_W-1:0]   r_rightAcc;
    logic [Y_W-1:0]   r_topAcc;
    logic [Y_W-1:0]   r_bottomAcc;
    logic             r_hit;

    logic             w_black;
    logic [RUN_W-1:0] w_runInc;
    logic [RUN_W-1:0] w_runNext;
    logic [X_W-1:0]   w_runStartNext;
    logic [X_W-1:0]   w_runLastNext;
    logic             w_close;
    logic             w_qualify;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (en) begin
            case (r_state)
                IDLE:    if (frame_start) w_nextState = ACTIVE;
                ACTIVE: begin
                    if (frame_start)    w_nextState = ACTIVE;
                    else if (frame_end) w_nextState = REPORT;
                end
                REPORT:  w_nextState = frame_start ? ACTIVE : IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // A restart pulse in ACTIVE discards the pixel of that cycle along with the accumulators.
    always_comb begin
        busy      = 1'b0;
        w_process = 1'b0;
        w_report  = 1'b0;
        case (r_state)
            ACTIVE: begin
                busy      = 1'b1;
                w_process = en && !frame_start;
            end
            REPORT:  w_report = en;
            default: ;
        endcase
    end

    assign w_clear        = en && frame_start;
    assign w_black        = w_process && pix_valid && pix_black;
    assign w_runInc       = (r_runCount == RUN_MAX) ? RUN_MAX : r_runCount + RUN_W'(1);
    assign w_runNext      = w_black ? w_runInc : r_runCount;
    assign w_runStartNext = (w_black && r_runCount == '0) ? hcount : r_runStart;
    assign w_runLastNext  = w_black ? hcount : r_runLast;
    // frame_end closes an open run even without line_end; invalid cycles only pause it.
    assign w_close        = w_process && ((pix_valid && (!pix_black || line_end)) || frame_end);
    assign w_qualify      = w_close && (w_runNext >= RUN_MIN);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_runCount <= '0;
            r_runStart <= '0;
            r_runLast  <= '0;
        end else if (w_clear) begin
            r_runCount <= '0;
        end else if (w_process) begin
            r_runCount <= w_close ? '0 : w_runNext;
            r_runStart <= w_runStartNext;
            r_runLast  <= w_runLastNext;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_leftAcc   <= '0;
            r_rightAcc  <= '0;
            r_topAcc    <= '0;
            r_bottomAcc <= '0;
            r_hit       <= 1'b0;
        end else if (w_clear) begin
            r_leftAcc   <= '1;
            r_rightAcc  <= '0;
            r_topAcc    <= '0;
            r_bottomAcc <= '0;
            r_hit       <= 1'b0;
        end else if (w_qualify) begin
            r_leftAcc   <= (w_runStartNext < r_leftAcc) ? w_runStartNext : r_leftAcc;
            r_rightAcc  <= (w_runLastNext > r_rightAcc) ? w_runLastNext : r_rightAcc;
            if (!r_hit) begin
                r_topAcc <= vcount;
            end
            r_hit       <= 1'b1;
            r_bottomAcc <= vcount;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            left       <= '0;
            right      <= '0;
            top        <= '0;
            bottom     <= '0;
            bbox_valid <= 1'b0;
            bbox_empty <= 1'b0;
        end else begin
            bbox_valid <= w_report;
            if (w_report) begin
                left       <= r_hit ? r_leftAcc   : '0;
                right      <= r_hit ? r_rightAcc  : '0;
                top        <= r_hit ? r_topAcc    : '0;
                bottom     <= r_hit ? r_bottomAcc : '0;
                bbox_empty <= !r_hit;
            end
        end
    end

endmodule
